// File: rtl/slice_permutation_engine.sv
// Slice-serial permutation engine.
//
// Holds a state of DEPTH slices, each N*N bits wide (bit (x,y) at index x+N*y).
// Slices are loaded through a valid/ready handshake. A runtime-selected number of
// rounds then runs, and the slices are unloaded through a second valid/ready
// handshake. One round maps S to T with T[k] = chi(S[k-1 mod DEPTH]) and flips
// bit (0,0) of T[0] (iota).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, rounds     launch request and round count, both sampled in IDLE
//   slicein, inValid  input slice stream; putInput is its ready
//   sliceOut, outValid, outReady, outLast
//                     output slice stream; outLast marks slice DEPTH-1
//   ready, busy       idle indication and its complement
module slice_permutation_engine #(
  parameter int unsigned N          = 5,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned MAX_ROUNDS = 24,
  parameter int unsigned ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ROUND_W-1:0] rounds,
  input  logic [N*N-1:0]     slicein,
  input  logic               inValid,
  output logic               putInput,
  output logic [N*N-1:0]     sliceOut,
  output logic               outValid,
  input  logic               outReady,
  output logic               outLast,
  output logic               ready,
  output logic               busy
);

  localparam int unsigned W  = N * N;
  localparam int unsigned KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [KW-1:0]      LastK     = KW'(DEPTH - 1);
  localparam logic [KW:0]        DepthWide = (KW + 1)'(DEPTH);
  localparam logic [ROUND_W-1:0] MaxR      = ROUND_W'(MAX_ROUNDS);
  localparam logic [W-1:0]       IotaMask  = W'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StUnload} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       slices_q [DEPTH];
  logic [KW-1:0]      k_q, k_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] nrounds_q, nrounds_d;
  // Physical slot holding logical slice 0. Each round rotates the state by one
  // slice; instead of moving data, chi is applied in place and the base moves.
  logic [KW-1:0]      base_q, base_d;
  logic [KW-1:0]      base_dec;
  logic [KW:0]        phys_sum;
  logic [KW-1:0]      phys_k;

  logic               wr_en;
  logic [W-1:0]       wr_data;
  logic [W-1:0]       chi_in;
  logic [W-1:0]       chi_out;

  assign base_dec = (base_q == '0) ? LastK : base_q - 1'b1;
  assign phys_sum = {1'b0, k_q} + {1'b0, base_q};
  assign phys_k   = (phys_sum >= DepthWide) ? KW'(phys_sum - DepthWide) : phys_sum[KW-1:0];

  // In COMPUTE the sweep visits physical slots directly; chi is slice-local.
  assign chi_in = slices_q[k_q];

  for (genvar gy = 0; gy < N; gy++) begin : g_chi_row
    for (genvar gx = 0; gx < N; gx++) begin : g_chi_bit
      assign chi_out[gx + N*gy] = chi_in[gx + N*gy] ^
                                  (~chi_in[((gx + 1) % N) + N*gy] &
                                    chi_in[((gx + 2) % N) + N*gy]);
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    round_d   = round_q;
    nrounds_d = nrounds_q;
    base_d    = base_q;
    wr_en     = 1'b0;
    wr_data   = chi_out;
    putInput  = 1'b0;
    outValid  = 1'b0;
    outLast   = 1'b0;
    ready     = 1'b0;
    sliceOut  = '0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          nrounds_d = (rounds > MaxR) ? MaxR : rounds;
          k_d       = '0;
          round_d   = '0;
          base_d    = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        putInput = 1'b1;
        if (inValid) begin
          wr_en   = 1'b1;
          wr_data = slicein;
          if (k_q == LastK) begin
            k_d     = '0;
            state_d = (nrounds_q != '0) ? StCompute : StUnload;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StCompute: begin
        wr_en = 1'b1;
        // After this round logical slice 0 lives at base_dec; iota lands there.
        wr_data = (k_q == base_dec) ? (chi_out ^ IotaMask) : chi_out;
        if (k_q == LastK) begin
          k_d     = '0;
          base_d  = base_dec;
          round_d = round_q + 1'b1;
          if (round_q + 1'b1 == nrounds_q) begin
            state_d = StUnload;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StUnload: begin
        outValid = 1'b1;
        sliceOut = slices_q[phys_k];
        outLast  = (k_q == LastK);
        if (outReady) begin
          if (k_q == LastK) begin
            k_d     = '0;
            state_d = StIdle;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      round_q   <= '0;
      nrounds_q <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      round_q   <= round_d;
      nrounds_q <= nrounds_d;
      base_q    <= base_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slices_q[i] <= '0;
      end
    end else if (wr_en) begin
      slices_q[k_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_slice_permutation_engine.sv
// Self-checking bench for slice_permutation_engine (N=5, DEPTH=4).
// Expected results come from an array-based model of the round definition.
module tb_slice_permutation_engine;

  localparam int unsigned N          = 5;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned MAX_ROUNDS = 24;
  localparam int unsigned ROUND_W    = 5;
  localparam int unsigned W          = N * N;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [ROUND_W-1:0] rounds = '0;
  logic [W-1:0]       slicein = '0;
  logic               inValid = 1'b0;
  logic               putInput;
  logic [W-1:0]       sliceOut;
  logic               outValid;
  logic               outReady = 1'b0;
  logic               outLast;
  logic               ready;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] in_data  [DEPTH];
  logic [W-1:0] exp_data [DEPTH];

  slice_permutation_engine #(
    .N          (N),
    .DEPTH      (DEPTH),
    .MAX_ROUNDS (MAX_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rounds   (rounds),
    .slicein  (slicein),
    .inValid  (inValid),
    .putInput (putInput),
    .sliceOut (sliceOut),
    .outValid (outValid),
    .outReady (outReady),
    .outLast  (outLast),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_chi(input logic [W-1:0] s);
    logic [W-1:0] o;
    for (int y = 0; y < N; y++) begin
      for (int x = 0; x < N; x++) begin
        o[x + N*y] = s[x + N*y] ^ (~s[(x + 1) % N + N*y] & s[(x + 2) % N + N*y]);
      end
    end
    return o;
  endfunction

  // Whole-state model: T[k] = chi(S[k-1]), then flip bit 0 of T[0], min(r, MAX) times.
  task automatic build_expected(input int r);
    logic [W-1:0] s [DEPTH];
    logic [W-1:0] t [DEPTH];
    int eff;
    eff = (r > int'(MAX_ROUNDS)) ? int'(MAX_ROUNDS) : r;
    for (int k = 0; k < DEPTH; k++) s[k] = in_data[k];
    for (int i = 0; i < eff; i++) begin
      for (int k = 0; k < DEPTH; k++) t[k] = ref_chi(s[(k + DEPTH - 1) % DEPTH]);
      t[0][0] = ~t[0][0];
      for (int k = 0; k < DEPTH; k++) s[k] = t[k];
    end
    for (int k = 0; k < DEPTH; k++) exp_data[k] = s[k];
  endtask

  // Runs one full operation starting at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic run_op(input int r, input bit gaps, input bit use_model, input string name);
    int  exp_cyc;
    int  cyc;
    int  idx;
    int  guard;
    bit  stalled;
    logic [W-1:0] held;

    if (use_model) build_expected(r);
    exp_cyc = ((r > int'(MAX_ROUNDS)) ? int'(MAX_ROUNDS) : r) * int'(DEPTH);

    check_eq({name, ".ready_idle"}, ready, 1'b1);
    rounds = ROUND_W'(r);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    rounds = ROUND_W'($urandom);  // must not affect the latched count

    idx = 0;
    guard = 0;
    while (idx < int'(DEPTH)) begin
      if (guard++ > 200) begin
        check_eq({name, ".load_timeout"}, 64'(idx), 64'(DEPTH));
        return;
      end
      check_eq({name, ".putInput_load"}, putInput, 1'b1);
      check_eq({name, ".busy_load"}, busy, 1'b1);
      inValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      slicein = inValid ? in_data[idx] : W'($urandom);
      start   = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (inValid) idx++;
    end
    inValid = 1'b0;
    start   = 1'b0;

    cyc = 0;
    while (!outValid) begin
      if (cyc > exp_cyc + 50) begin
        check_eq({name, ".compute_timeout"}, 64'(cyc), 64'(exp_cyc));
        return;
      end
      check_eq({name, ".putInput_compute"}, putInput, 1'b0);
      check_eq({name, ".busy_compute"}, busy, 1'b1);
      inValid = 1'($urandom_range(0, 1));
      slicein = W'($urandom);
      start   = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    inValid = 1'b0;
    start   = 1'b0;
    check_eq({name, ".compute_cycles"}, 64'(cyc), 64'(exp_cyc));

    idx = 0;
    guard = 0;
    stalled = 1'b0;
    held = '0;
    while (idx < int'(DEPTH)) begin
      if (guard++ > 200) begin
        check_eq({name, ".unload_timeout"}, 64'(idx), 64'(DEPTH));
        return;
      end
      check_eq({name, ".outValid"}, outValid, 1'b1);
      check_eq({name, ".outLast"}, outLast, (idx == int'(DEPTH) - 1));
      if (stalled) check_eq({name, ".stable"}, sliceOut, held);
      outReady = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (outReady) check_eq($sformatf("%s.slice%0d", name, idx), sliceOut, exp_data[idx]);
      held    = sliceOut;
      stalled = !outReady;
      start   = (gaps && idx < int'(DEPTH) - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (outReady) idx++;
    end
    outReady = 1'b0;
    start    = 1'b0;
    check_eq({name, ".outValid_done"}, outValid, 1'b0);
    check_eq({name, ".ready_done"}, ready, 1'b1);
    check_eq({name, ".outLast_done"}, outLast, 1'b0);
  endtask

  initial begin
    #2;
    check_eq("reset.ready", ready, 1'b1);
    check_eq("reset.busy", busy, 1'b0);
    check_eq("reset.putInput", putInput, 1'b0);
    check_eq("reset.outValid", outValid, 1'b0);
    check_eq("reset.outLast", outLast, 1'b0);
    check_eq("reset.sliceOut", sliceOut, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All-zero state, one round.
    for (int k = 0; k < DEPTH; k++) in_data[k] = '0;
    exp_data[0] = 25'h0000001; exp_data[1] = '0; exp_data[2] = '0; exp_data[3] = '0;
    run_op(1, 1'b0, 1'b0, "zero_r1");

    // All-zero state, two rounds.
    exp_data[0] = 25'h0000001; exp_data[1] = 25'h0000009; exp_data[2] = '0; exp_data[3] = '0;
    run_op(2, 1'b0, 1'b0, "zero_r2");

    // Zero rounds is a pass-through.
    for (int k = 0; k < DEPTH; k++) begin
      in_data[k]  = W'(k + 1);
      exp_data[k] = W'(k + 1);
    end
    run_op(0, 1'b0, 1'b0, "passthru");

    // Round count above the maximum saturates.
    for (int k = 0; k < DEPTH; k++) in_data[k] = W'($urandom);
    run_op(31, 1'b0, 1'b1, "sat_r31");

    // Asynchronous reset in the middle of COMPUTE.
    for (int k = 0; k < DEPTH; k++) in_data[k] = W'($urandom);
    rounds = 5'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      inValid = 1'b1;
      slicein = in_data[k];
      @(negedge clk);
    end
    inValid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst.busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst.ready", ready, 1'b1);
    check_eq("midrst.busy", busy, 1'b0);
    check_eq("midrst.outValid", outValid, 1'b0);
    check_eq("midrst.sliceOut", sliceOut, '0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst.outValid_after", outValid, 1'b0);
    for (int k = 0; k < DEPTH; k++) in_data[k] = W'($urandom);
    run_op(7, 1'b0, 1'b1, "after_rst");

    // Randomised runs with handshake gaps and stray start pulses.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < DEPTH; k++) in_data[k] = W'($urandom);
      run_op(int'($urandom_range(0, 31)), 1'b1, 1'b1, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
